counter_mode_ctrl: RTL

Control stage directly upstream of the up/down counter. Converts two raw push-button inputs (load, mode) into the counter's `load_en`, `up_down` and `counter_in` controls. Reads `counter_out` back so that in bounce mode the counter reverses at its limits instead of wrapping. Each button passes through a synchroniser and a debouncer before it can act.

---
 rtl/counter_pkg.sv | 16 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/counter_mode_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter control slice: mode encodings and counter limit helper.
// Pure definitions, no latency, no flow control.
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'd0,
      MODE_DOWN   = 2'd1,
      MODE_BOUNCE = 2'd2
   } mode_t;

   // Largest value representable by a counter of the given width.
   function automatic logic [31:0] CNT_MAX(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> debounce -> one-cycle press pulse on debounced rising edge.
// Pulse is combinational from registers, DEBOUNCE_CYCLES+1 edges after first sample; no backpressure.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_ff1;
   logic          sync_ff2;
   logic          deb;
   logic          deb_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff1 <= 1'b0;
         sync_ff2 <= 1'b0;
         deb      <= 1'b0;
         deb_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         sync_ff1 <= btn;
         sync_ff2 <= sync_ff1;
         deb_q    <= deb;
         // Any cycle where the synchronised level agrees restarts the stability window.
         if (sync_ff2 == deb) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press = deb & ~deb_q;

endmodule

// File: rtl/counter_mode_ctrl.sv
// Turns debounced load/mode buttons into load_en/up_down/counter_in for the up/down counter.
// Controls register DEBOUNCE_CYCLES+2 edges after a press; bounce reversal has zero slack; no backpressure.
module counter_mode_ctrl
   import counter_pkg::*;
#(
   parameter int CNT_WIDTH       = 3,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 btn_load,
   input  logic                 btn_mode,
   input  logic [CNT_WIDTH-1:0] load_value,
   input  logic [CNT_WIDTH-1:0] counter_out,
   output logic                 load_en,
   output logic                 up_down,
   output logic [CNT_WIDTH-1:0] counter_in,
   output logic [1:0]           mode
);

   localparam logic [CNT_WIDTH-1:0] MAX    = CNT_WIDTH'(CNT_MAX(CNT_WIDTH));
   localparam logic [CNT_WIDTH-1:0] MAX_M1 = CNT_WIDTH'(CNT_MAX(CNT_WIDTH) - 32'd1);
   localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

   mode_t mode_q;
   logic  load_evt;
   logic  mode_evt;
   logic  load_top;
   logic  load_bottom;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_load_db (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_load),
      .press   (load_evt)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode_db (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_mode),
      .press   (mode_evt)
   );

   assign load_top    = load_evt && (load_value == MAX);
   assign load_bottom = load_evt && (load_value == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_en    <= 1'b0;
         up_down    <= 1'b1;
         counter_in <= '0;
         mode_q     <= MODE_UP;
      end else begin
         load_en <= load_evt;
         if (load_evt) begin
            counter_in <= load_value;
         end

         if (mode_evt) begin
            case (mode_q)
               MODE_UP: begin
                  mode_q  <= MODE_DOWN;
                  up_down <= 1'b0;
               end
               MODE_DOWN: begin
                  // Direction carries over into BOUNCE unless a coincident load pins it.
                  mode_q <= MODE_BOUNCE;
                  if (load_top) begin
                     up_down <= 1'b0;
                  end else if (load_bottom) begin
                     up_down <= 1'b1;
                  end
               end
               default: begin
                  mode_q  <= MODE_UP;
                  up_down <= 1'b1;
               end
            endcase
         end else if (mode_q == MODE_BOUNCE) begin
            if (load_evt) begin
               if (load_top) begin
                  up_down <= 1'b0;
               end else if (load_bottom) begin
                  up_down <= 1'b1;
               end
            end else if (!load_en) begin
               // counter_out is stale while a load is in flight, so skip that cycle.
               if (up_down && (counter_out == MAX_M1)) begin
                  up_down <= 1'b0;
               end else if (!up_down && (counter_out == ONE)) begin
                  up_down <= 1'b1;
               end
            end
         end
      end
   end

   assign mode = mode_q;

endmodule
